window_3x3_buffer: RTL and testbench

- Line-buffered 3x3 neighbourhood generator that sits directly upstream of the Sobel stage inside top.
- Consumes the raster pixel stream (data, en) together with the x/y co-ordinates from location_generator.
- Presents all nine pixels of the window centred on (x-1, y-1) to the edge-detection kernel, one window per enabled cycle.
- Two internal line memories hold the previous two rows.

---
 rtl/window_3x3_buffer.sv | 100 ++++++++++
 tb/tb_window_3x3_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_buffer.sv
// Line-buffered 3x3 neighbourhood generator feeding the Sobel stage.
// Two line memories hold the previous two rows. A 3x3 shift register
// assembles the window, with the newest column entering on the right.
// reset_n is an active-high asynchronous reset despite its name; the port
// name is kept because the surrounding design already connects to it.
module window_3x3_buffer #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 640,
    parameter int COORD_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [COORD_W-1:0]    x,
    input  logic [COORD_W-1:0]    y,
    input  logic [DATA_W-1:0]     data,
    output logic [9*DATA_W-1:0]   window,
    output logic                  out_valid,
    output logic [COORD_W-1:0]    out_x,
    output logic [COORD_W-1:0]    out_y,
    output logic                  overrun
);

    localparam int                 ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [COORD_W-1:0] MAX_X  = COORD_W'(MAX_WIDTH);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);
    localparam logic [COORD_W-1:0] TWO    = COORD_W'(2);

    // line0 holds row y-1 and line1 holds row y-2. Neither is reset: out_valid
    // stays low until both rows have been rewritten by the current stream.
    logic [DATA_W-1:0] line0 [MAX_WIDTH];
    logic [DATA_W-1:0] line1 [MAX_WIDTH];

    // p[r][c]: r = 0 is the top row, c = 2 is the newest column.
    logic [DATA_W-1:0] p [3][3];

    logic              accept;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] col_top;
    logic [DATA_W-1:0] col_mid;

    assign accept  = en && (x < MAX_X);
    assign addr    = x[ADDR_W-1:0];
    assign col_top = line1[addr];
    assign col_mid = line0[addr];

    // Line memories: read-before-write, so row y-1 moves down into the y-2 slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            line1[addr] <= col_mid;
            line0[addr] <= data;
        end
    end

    // Window shift: each row moves left and the fresh column enters at c = 2.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    p[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                p[r][0] <= p[r][1];
                p[r][1] <= p[r][2];
            end
            p[0][2] <= col_top;
            p[1][2] <= col_mid;
            p[2][2] <= data;
        end
    end

    // Taps are the shift registers themselves, so the window is already registered.
    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign window[(3*r+c)*DATA_W +: DATA_W] = p[r][c];
        end
    end

    // Window qualification, centre coordinates and the sticky overrun flag.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= accept && (x >= TWO) && (y >= TWO);
            if (accept) begin
                out_x <= x - ONE;
                out_y <= y - ONE;
            end
            if (en && !accept) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_buffer.sv
// Directed bench for window_3x3_buffer. A reference model keeps the full
// per-column history of written pixels plus the last three accepted columns.
// A single compare process checks every output against that model on each
// falling edge. Literal expectations pin the model at key points.
module tb_window_3x3_buffer;

    localparam int DW    = 8;
    localparam int MW    = 640;
    localparam int CW    = 16;
    localparam int IMG_W = 8;
    localparam int IMG_H = 4;

    logic              clk     = 1'b0;
    logic              reset_n = 1'b0;
    logic              en      = 1'b0;
    logic [CW-1:0]     x       = '0;
    logic [CW-1:0]     y       = '0;
    logic [DW-1:0]     data    = '0;
    logic [9*DW-1:0]   window;
    logic              out_valid;
    logic [CW-1:0]     out_x;
    logic [CW-1:0]     out_y;
    logic              overrun;

    window_3x3_buffer #(.DATA_W(DW), .MAX_WIDTH(MW), .COORD_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .x         (x),
        .y         (y),
        .data      (data),
        .window    (window),
        .out_valid (out_valid),
        .out_x     (out_x),
        .out_y     (out_y),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int v [9]);
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = v[i][7:0];
        return w;
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic             known;
        logic [2:0][7:0]  v;      // v[0]=top, v[1]=mid, v[2]=bottom
    } col_t;

    col_t          cols [$];
    logic [7:0]    hist [MW][$];
    logic          m_valid;
    logic [CW-1:0] m_ox;
    logic [CW-1:0] m_oy;
    logic          m_ovr;
    col_t          nc;
    int            nh;

    function automatic void model_reset();
        col_t z;
        z = '0;
        z.known = 1'b1;
        cols.delete();
        for (int i = 0; i < 3; i++) cols.push_back(z);
        m_valid = 1'b0;
        m_ox    = '0;
        m_oy    = '0;
        m_ovr   = 1'b0;
    endfunction

    function automatic logic [71:0] model_window();
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                w[(3*r+c)*8 +: 8] = cols[c].v[r];
        return w;
    endfunction

    always @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            model_reset();
        end else if (en) begin
            if (int'(x) >= MW) begin
                m_ovr   = 1'b1;
                m_valid = 1'b0;
            end else begin
                nh       = hist[x].size();
                nc.known = (nh >= 2);
                nc.v[0]  = (nh >= 2) ? hist[x][nh-2] : 8'h00;
                nc.v[1]  = (nh >= 1) ? hist[x][nh-1] : 8'h00;
                nc.v[2]  = data;
                hist[x].push_back(data);
                cols.push_back(nc);
                void'(cols.pop_front());
                m_valid = (int'(x) >= 2) && (int'(y) >= 2);
                m_ox    = x - 1;
                m_oy    = y - 1;
            end
        end else begin
            m_valid = 1'b0;
        end
    end

    // Compare process: every falling edge, all outputs against the model.
    always @(negedge clk) begin
        if (cols.size() == 3) begin
            check("out_valid", out_valid, m_valid);
            check("out_x", out_x, m_ox);
            check("out_y", out_y, m_oy);
            check("overrun", overrun, m_ovr);
            if (cols[0].known && cols[1].known && cols[2].known)
                check("window", window, model_window());
        end
    end

    // ---------------- stimulus ----------------
    task automatic pix(input int px, input int py, input int pd, input bit pen);
        x    = CW'(px);
        y    = CW'(py);
        data = DW'(pd);
        en   = pen;
        @(posedge clk);
        #1;
    endtask

    int          vcnt;
    int          bad;
    int          first_x;
    int          first_y;
    logic [71:0] saved;

    initial begin
        #2 reset_n = 1'b1;
        #1;
        check("reset_window", window, 72'h0);
        check("reset_valid", out_valid, 1'b0);
        check("reset_out_x", out_x, 16'h0);
        check("reset_out_y", out_y, 16'h0);
        check("reset_overrun", overrun, 1'b0);
        @(posedge clk);
        #1 reset_n = 1'b0;

        // Frame A: ramp with a 5-cycle enable gap after pixel (4,2).
        vcnt = 0; first_x = -1; first_y = -1;
        for (int yy = 0; yy < IMG_H; yy++) begin
            for (int xx = 0; xx < IMG_W; xx++) begin
                if (yy == 2 && xx == 5) begin
                    saved = window;
                    repeat (5) begin
                        pix(xx, yy, 16*yy + xx, 1'b0);
                        check("gap_hold_window", window, saved);
                        check("gap_valid_low", out_valid, 1'b0);
                    end
                    check("gap_window_lit", window, pack9('{2,3,4,18,19,20,34,35,36}));
                    check("gap_out_x", out_x, 16'd3);
                end
                pix(xx, yy, 16*yy + xx, 1'b1);
                if (out_valid) begin
                    vcnt++;
                    if (first_x < 0) begin first_x = xx; first_y = yy; end
                end
                if (yy == 2 && xx == 2) begin
                    check("first_window", window, pack9('{0,1,2,16,17,18,32,33,34}));
                    check("first_valid", out_valid, 1'b1);
                    check("first_out_x", out_x, 16'd1);
                    check("first_out_y", out_y, 16'd1);
                end
                if (yy == 2 && xx == 5) begin
                    check("resume_window", window, pack9('{3,4,5,19,20,21,35,36,37}));
                    check("resume_out_x", out_x, 16'd4);
                    check("resume_out_y", out_y, 16'd1);
                end
            end
        end
        check("frameA_valid_count", 72'(vcnt), 72'd12);
        check("frameA_first_x", 72'(first_x), 72'd2);
        check("frameA_first_y", 72'(first_y), 72'd2);

        // Frame B: back-to-back, data offset by 100.
        vcnt = 0; bad = 0; first_x = -1; first_y = -1;
        for (int yy = 0; yy < IMG_H; yy++) begin
            for (int xx = 0; xx < IMG_W; xx++) begin
                pix(xx, yy, 100 + 16*yy + xx, 1'b1);
                if (out_valid) begin
                    vcnt++;
                    if (first_x < 0) begin first_x = xx; first_y = yy; end
                    for (int t = 0; t < 9; t++)
                        if (window[t*8 +: 8] < 8'd100) bad++;
                end
                if (yy == 2 && xx == 2)
                    check("frameB_first_window", window,
                          pack9('{100,101,102,116,117,118,132,133,134}));
            end
        end
        check("frameB_valid_count", 72'(vcnt), 72'd12);
        check("frameB_first_y", 72'(first_y), 72'd2);
        check("frameB_stale_taps", 72'(bad), 72'd0);

        // Overrun: illegal column, then legal rows 0..2 of frame C.
        saved = window;
        pix(MW, 0, 77, 1'b1);
        check("overrun_set", overrun, 1'b1);
        check("overrun_valid", out_valid, 1'b0);
        check("overrun_window", window, saved);
        for (int yy = 0; yy < 3; yy++)
            for (int xx = 0; xx < IMG_W; xx++)
                pix(xx, yy, 16*yy + xx, 1'b1);
        check("overrun_sticky", overrun, 1'b1);

        // Asynchronous reset between clock edges, before row 3 of frame C.
        en = 1'b0;
        #2 reset_n = 1'b1;
        #1;
        check("midreset_window", window, 72'h0);
        check("midreset_valid", out_valid, 1'b0);
        check("midreset_out_x", out_x, 16'h0);
        check("midreset_out_y", out_y, 16'h0);
        check("midreset_overrun", overrun, 1'b0);
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(posedge clk);
        #1;
        for (int xx = 0; xx < IMG_W; xx++) begin
            pix(xx, 3, 48 + xx, 1'b1);
            if (xx < 2) check("postreset_valid_low", out_valid, 1'b0);
            if (xx == 2) begin
                check("postreset_window", window, pack9('{16,17,18,32,33,34,48,49,50}));
                check("postreset_valid", out_valid, 1'b1);
                check("postreset_out_x", out_x, 16'd1);
                check("postreset_out_y", out_y, 16'd2);
            end
        end
        en = 1'b0;
        @(posedge clk);
        #1;
        check("postreset_overrun_clear", overrun, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
